cordic_rotator: RTL and testbench

Iterative rotation-mode CORDIC engine that turns a Q3.29 angle into Q3.29 cosine and sine. It sits directly downstream of `arctan_lookup`: it drives that table's 5-bit index `j` from its iteration counter and consumes the returned arctan constant in the same cycle. It performs one micro-rotation per clock and connects to the rest of the design through valid/ready handshakes on input and output.

---
 rtl/cordic_rotator_if.sv | 15 +
 rtl/cordic_rotator.sv | 98 +++++++++
 tb/tb_cordic_rotator.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cordic_rotator_if.sv
// Valid/ready handshake bundle between the CORDIC engine and its producer/consumer.
interface cordic_rotator_if #(parameter int N = 32);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] angle_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] cos_out;
  logic signed [N-1:0] sin_out;

  modport master (output in_valid, angle_in, out_ready,
                  input  in_ready, out_valid, cos_out, sin_out);
  modport slave  (input  in_valid, angle_in, out_ready,
                  output in_ready, out_valid, cos_out, sin_out);
endinterface

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, Q3.29 angle in, cos/sin out.
module cordic_rotator #(
  parameter int N    = 32,
  parameter int ITER = 28
) (
  input  logic                clk,
  input  logic                rst,
  cordic_rotator_if.slave     bus,
  output logic [4:0]          j,
  input  logic signed [N-1:0] arctan
);
  localparam logic signed [N-1:0] PI      = 1686629713;
  localparam logic signed [N-1:0] HALF_PI = 843314857;
  localparam logic signed [N-1:0] K       = 326016437;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, nxt;
  logic signed [N-1:0] x, y, z, xn, yn, zn, zf, cos_q, sin_q;
  logic [4:0]          i;
  logic                neg, negf, accept, last;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;
  assign j             = (state == RUN) ? i : 5'd0;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = (i == 5'(ITER - 1));

  // Fold into [-pi/2, pi/2]; the result is negated at the end to compensate.
  always_comb begin
    zf   = bus.angle_in;
    negf = 1'b0;
    if (bus.angle_in > HALF_PI) begin
      zf   = bus.angle_in - PI;
      negf = 1'b1;
    end else if (bus.angle_in < -HALF_PI) begin
      zf   = bus.angle_in + PI;
      negf = 1'b1;
    end
  end

  always_comb begin
    if (!z[N-1]) begin
      xn = x - (y >>> i);
      yn = y + (x >>> i);
      zn = z - arctan;
    end else begin
      xn = x + (y >>> i);
      yn = y - (x >>> i);
      zn = z + arctan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0; y <= '0; z <= '0; i <= '0; neg <= 1'b0;
      cos_q <= '0; sin_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x   <= K;
          y   <= '0;
          z   <= zf;
          neg <= negf;
          i   <= '0;
        end
        RUN: begin
          x <= xn;
          y <= yn;
          z <= zn;
          i <= i + 5'd1;
          if (last) begin
            cos_q <= neg ? -xn : xn;
            sin_q <= neg ? -yn : yn;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench: spec vectors, random angles vs real-math cos/sin, backpressure and reset abort.
module tb_cordic_rotator;
  localparam int ITER = 28;
  localparam longint PI_Q = 1686629713;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] j;
  logic signed [31:0] arctan;
  int checks = 0;
  int failures = 0;

  cordic_rotator_if #(.N(32)) bus ();
  cordic_rotator #(.N(32), .ITER(ITER)) dut (.clk(clk), .rst(rst), .bus(bus), .j(j), .arctan(arctan));

  always #5 clk = ~clk;

  // Stand-in for arctan_lookup: round(atan(2^-k) * 2^29).
  function automatic logic signed [31:0] atan_q(input logic [4:0] k);
    real p = 1.0;
    for (int n = 0; n < int'(k); n++) p = p / 2.0;
    return 32'($rtoi($atan(p) * 536870912.0 + 0.5));
  endfunction
  assign arctan = atan_q(j);

  function automatic longint rnd(input real r);
    return longint'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    longint d = act - exp;
    checks++;
    if (d > tol || d < -tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Issue one angle and wait (bounded) for out_valid; does not complete the output handshake itself.
  task automatic run(input logic signed [31:0] a, output logic signed [31:0] c, output logic signed [31:0] s,
                     output int lat, output bit jbad);
    int w = 0;
    jbad = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    bus.angle_in = a;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      if (int'(j) != lat - 1) jbad = 1;
      @(negedge clk);
      lat++;
    end
    c = bus.cos_out;
    s = bus.sin_out;
  endtask

  typedef struct {
    string              name;
    logic signed [31:0] angle;
    longint             cos_e;
    longint             sin_e;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic signed [31:0] c, s, c0, s0;
    int lat;
    bit jbad, bad;

    vecs[0] = '{"zero",    32'sd0,           536870912, 0};
    vecs[1] = '{"pi_6",    32'sd281104952,   464943849, 268435456};
    vecs[2] = '{"m_pi_2", -32'sd843314857,   0,         -536870912};
    vecs[3] = '{"3pi_4",   32'sd1264972285, -379625062, 379625062};

    bus.in_valid  = 1'b0;
    bus.angle_in  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0, 0);
    chk("rst_out_valid", bus.out_valid, 0, 0);
    chk("rst_cos", bus.cos_out, 0, 0);
    chk("rst_sin", bus.sin_out, 0, 0);
    chk("rst_j", j, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1, 0);

    for (int k = 0; k < 4; k++) begin
      run(vecs[k].angle, c, s, lat, jbad);
      chk({vecs[k].name, "_latency"}, lat, ITER + 1, 0);
      chk({vecs[k].name, "_j_seq"}, jbad, 0, 0);
      chk({vecs[k].name, "_cos"}, c, vecs[k].cos_e, 32);
      chk({vecs[k].name, "_sin"}, s, vecs[k].sin_e, 32);
      @(negedge clk);
      chk({vecs[k].name, "_ready_after"}, bus.in_ready, 1, 0);
    end

    for (int k = 0; k < 24; k++) begin
      longint a = longint'($urandom_range(32'd3373259426, 0)) - PI_Q;
      real ar = real'(a) / 536870912.0;
      run(32'(a), c, s, lat, jbad);
      chk($sformatf("rand%0d_cos a=%0d", k, a), c, rnd($cos(ar) * 536870912.0), 32);
      chk($sformatf("rand%0d_sin a=%0d", k, a), s, rnd($sin(ar) * 536870912.0), 32);
      @(negedge clk);
    end

    // Backpressure: result holds, in_ready low, stray in_valid ignored.
    bus.out_ready = 1'b0;
    run(32'sd281104952, c0, s0, lat, jbad);
    chk("bp_valid", bus.out_valid, 1, 0);
    bad = 0;
    bus.angle_in = 32'sd0;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.cos_out != c0 || bus.sin_out != s0) bad = 1;
    end
    chk("bp_hold", bad, 0, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", bus.in_ready, 1, 0);
    chk("bp_valid_after", bus.out_valid, 0, 0);
    chk("bp_cos", c0, 464943849, 32);

    // Reset while iteration 10 is executing.
    bus.angle_in = 32'sd281104952;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_j", j, 10, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", bus.in_ready, 0, 0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid || bus.cos_out != 0 || bus.sin_out != 0 || !bus.in_ready) bad = 1;
    end
    chk("mid_rst_quiet", bad, 0, 0);
    run(32'sd0, c, s, lat, jbad);
    chk("post_rst_latency", lat, ITER + 1, 0);
    chk("post_rst_cos", c, 536870912, 32);
    chk("post_rst_sin", s, 0, 32);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
